hilo_muldiv: RTL and testbench

Multi-cycle multiply/divide unit owning the MIPS HI/LO register pair, sitting beside the 32-bit ALU in the EX stage. It accepts a command (MULT/MULTU/DIV/DIVU/MTHI/MTLO, plus optional MADD/MSUB) with two 32-bit operands and iterates one bit per cycle. On completion it updates HI/LO and pulses a done flag. The hazard unit stalls MFHI/MFLO and new HI/LO commands while `Busy` is high.

---
 rtl/hilo_pkg.sv | 26 ++
 rtl/hilo_divstep.sv | 17 +
 rtl/hilo_muldiv.sv | 214 +++++++++++++++++++++
 tb/tb_hilo_muldiv.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hilo_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: command codes,
// FSM state encoding and the iteration count.
package hilo_pkg;

  localparam logic [3:0] OP_MULT  = 4'b0000;
  localparam logic [3:0] OP_MULTU = 4'b0001;
  localparam logic [3:0] OP_DIV   = 4'b0010;
  localparam logic [3:0] OP_DIVU  = 4'b0011;
  localparam logic [3:0] OP_MTHI  = 4'b0100;
  localparam logic [3:0] OP_MTLO  = 4'b0101;
  localparam logic [3:0] OP_MADD  = 4'b0110;
  localparam logic [3:0] OP_MADDU = 4'b0111;
  localparam logic [3:0] OP_MSUB  = 4'b1000;
  localparam logic [3:0] OP_MSUBU = 4'b1001;

  // Counter value loaded at accept; one iteration per cycle down to zero.
  localparam int ITER_LAST = 31;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX
  } state_e;

endpackage

// File: rtl/hilo_divstep.sv
// One restoring-division step: compare the shifted partial remainder with
// the divisor, subtract when it fits, and emit the quotient bit.
module hilo_divstep #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             qbit_o
);

  // When the step succeeds the result is below the divisor, so the low
  // WIDTH bits of the subtraction are exact.
  assign qbit_o = (rem_i >= {1'b0, divisor_i});
  assign rem_o  = qbit_o ? (rem_i[WIDTH-1:0] - divisor_i) : rem_i[WIDTH-1:0];

endmodule

// File: rtl/hilo_muldiv.sv
// Multi-cycle MIPS multiply/divide unit owning HI/LO, one bit per cycle.
// Define HILO_MADD_EN to decode the MADD/MADDU/MSUB/MSUBU accumulate ops.
module hilo_muldiv
  import hilo_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             Clk_i,
  input  logic             Reset_i,
  input  logic             Start_i,
  input  logic [3:0]       Op_i,
  input  logic [WIDTH-1:0] A_i,
  input  logic [WIDTH-1:0] B_i,
  output logic             Busy_o,
  output logic             Done_o,
  output logic             DivByZero_o,
  output logic [WIDTH-1:0] Hi_o,
  output logic [WIDTH-1:0] Lo_o
);

  localparam int CntW = $clog2(ITER_LAST + 1);

  state_e             stateQ, stateD;
  logic [CntW-1:0]    cntQ, cntD;
  logic [2*WIDTH-1:0] accQ, accD;
  logic [WIDTH-1:0]   remQ, remD;
  logic [WIDTH-1:0]   opBQ, opBD;
  logic               negLoQ, negLoD;
  logic               negHiQ, negHiD;
  logic               divQ, divD;
  logic [WIDTH-1:0]   hiQ, hiD;
  logic [WIDTH-1:0]   loQ, loD;
  logic               doneQ, doneD;
  logic               dbzQ, dbzD;

  logic               isSgn, isMul, isMulBase, isDiv;
  logic [WIDTH-1:0]   magA, magB, srcA, srcB;
  logic [WIDTH:0]     mulSum;
  logic [2*WIDTH-1:0] mulNext;
  logic [2*WIDTH-1:0] prodFix;
  logic [WIDTH-1:0]   quoFix, remFix;
  logic [WIDTH-1:0]   stepRem;
  logic               stepBit;

  // Even op codes are the signed variants of each command pair.
  assign isSgn     = ~Op_i[0];
  assign isMulBase = (Op_i == OP_MULT) || (Op_i == OP_MULTU);
  assign isDiv     = (Op_i == OP_DIV)  || (Op_i == OP_DIVU);

`ifdef HILO_MADD_EN
  logic isMacc, isSub;
  logic maccQ, maccD;
  logic subQ, subD;
  assign isMacc = (Op_i == OP_MADD) || (Op_i == OP_MADDU) ||
                  (Op_i == OP_MSUB) || (Op_i == OP_MSUBU);
  assign isSub  = (Op_i == OP_MSUB) || (Op_i == OP_MSUBU);
  assign isMul  = isMulBase || isMacc;
`else
  assign isMul  = isMulBase;
`endif

  assign magA = A_i[WIDTH-1] ? (-A_i) : A_i;
  assign magB = B_i[WIDTH-1] ? (-B_i) : B_i;
  assign srcA = isSgn ? magA : A_i;
  assign srcB = isSgn ? magB : B_i;

  // Shift-add step: conditionally add the multiplicand into the upper half,
  // then shift the whole accumulator right with the carry coming in on top.
  assign mulSum  = {1'b0, accQ[2*WIDTH-1:WIDTH]} + {1'b0, opBQ};
  assign mulNext = accQ[0] ? {mulSum, accQ[WIDTH-1:1]}
                           : {1'b0, accQ[2*WIDTH-1:1]};

  hilo_divstep #(.WIDTH(WIDTH)) uDivStep (
    .rem_i     ({remQ, accQ[WIDTH-1]}),
    .divisor_i (opBQ),
    .rem_o     (stepRem),
    .qbit_o    (stepBit)
  );

  assign prodFix = negLoQ ? (-accQ) : accQ;
  assign quoFix  = negLoQ ? (-accQ[WIDTH-1:0]) : accQ[WIDTH-1:0];
  assign remFix  = negHiQ ? (-remQ) : remQ;

  always_comb begin
    stateD = stateQ;
    cntD   = cntQ;
    accD   = accQ;
    remD   = remQ;
    opBD   = opBQ;
    negLoD = negLoQ;
    negHiD = negHiQ;
    divD   = divQ;
    hiD    = hiQ;
    loD    = loQ;
    doneD  = 1'b0;
    dbzD   = 1'b0;
`ifdef HILO_MADD_EN
    maccD  = maccQ;
    subD   = subQ;
`endif
    case (stateQ)
      S_IDLE: begin
        if (Start_i) begin
          if (isMul) begin
            opBD   = srcA;
            accD   = {{WIDTH{1'b0}}, srcB};
            negLoD = isSgn && (A_i[WIDTH-1] ^ B_i[WIDTH-1]);
            negHiD = 1'b0;
            divD   = 1'b0;
            cntD   = CntW'(ITER_LAST);
            stateD = S_MUL;
`ifdef HILO_MADD_EN
            maccD  = isMacc;
            subD   = isSub;
`endif
          end else if (isDiv) begin
            if (B_i == '0) begin
              doneD = 1'b1;
              dbzD  = 1'b1;
            end else begin
              opBD   = srcB;
              accD   = {{WIDTH{1'b0}}, srcA};
              remD   = '0;
              negLoD = isSgn && (A_i[WIDTH-1] ^ B_i[WIDTH-1]);
              negHiD = isSgn && A_i[WIDTH-1];
              divD   = 1'b1;
              cntD   = CntW'(ITER_LAST);
              stateD = S_DIV;
            end
          end else if (Op_i == OP_MTHI) begin
            hiD   = A_i;
            doneD = 1'b1;
          end else if (Op_i == OP_MTLO) begin
            loD   = A_i;
            doneD = 1'b1;
          end
        end
      end
      S_MUL: begin
        accD = mulNext;
        if (cntQ == '0) stateD = S_FIX;
        else            cntD   = cntQ - CntW'(1);
      end
      S_DIV: begin
        accD = {accQ[2*WIDTH-1:WIDTH], accQ[WIDTH-2:0], stepBit};
        remD = stepRem;
        if (cntQ == '0) stateD = S_FIX;
        else            cntD   = cntQ - CntW'(1);
      end
      S_FIX: begin
        doneD  = 1'b1;
        stateD = S_IDLE;
        if (divQ) begin
          hiD = remFix;
          loD = quoFix;
        end else begin
`ifdef HILO_MADD_EN
          if (maccQ && subQ)  {hiD, loD} = {hiQ, loQ} - prodFix;
          else if (maccQ)     {hiD, loD} = {hiQ, loQ} + prodFix;
          else                {hiD, loD} = prodFix;
`else
          {hiD, loD} = prodFix;
`endif
        end
      end
      default: stateD = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk_i) begin
    if (Reset_i) begin
      stateQ <= S_IDLE;
      cntQ   <= '0;
      accQ   <= '0;
      remQ   <= '0;
      opBQ   <= '0;
      negLoQ <= 1'b0;
      negHiQ <= 1'b0;
      divQ   <= 1'b0;
      hiQ    <= '0;
      loQ    <= '0;
      doneQ  <= 1'b0;
      dbzQ   <= 1'b0;
`ifdef HILO_MADD_EN
      maccQ  <= 1'b0;
      subQ   <= 1'b0;
`endif
    end else begin
      stateQ <= stateD;
      cntQ   <= cntD;
      accQ   <= accD;
      remQ   <= remD;
      opBQ   <= opBD;
      negLoQ <= negLoD;
      negHiQ <= negHiD;
      divQ   <= divD;
      hiQ    <= hiD;
      loQ    <= loD;
      doneQ  <= doneD;
      dbzQ   <= dbzD;
`ifdef HILO_MADD_EN
      maccQ  <= maccD;
      subQ   <= subD;
`endif
    end
  end

  assign Busy_o      = (stateQ != S_IDLE);
  assign Done_o      = doneQ;
  assign DivByZero_o = dbzQ;
  assign Hi_o        = hiQ;
  assign Lo_o        = loQ;

endmodule

// File: tb/tb_hilo_muldiv.sv
// Scoreboard bench for hilo_muldiv; exercises MADD ops when HILO_MADD_EN is defined.
module tb_hilo_muldiv;
  import hilo_pkg::*;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [3:0]  op;
  logic [31:0] a, b;
  logic        busy, done, dbz;
  logic [31:0] hi, lo;

  always #5 clk = ~clk;

  hilo_muldiv #(.WIDTH(32)) dut (
    .Clk_i(clk), .Reset_i(reset), .Start_i(start), .Op_i(op), .A_i(a), .B_i(b),
    .Busy_o(busy), .Done_o(done), .DivByZero_o(dbz), .Hi_o(hi), .Lo_o(lo)
  );

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          nCompared = 0;
  int          nMismatched = 0;
  logic [31:0] mHi = '0, mLo = '0;

  function automatic exp_t mkExp(input string n, input logic [31:0] h,
                                 input logic [31:0] l, input logic z, input int lt);
    exp_t e;
    e.name = n; e.hi = h; e.lo = l; e.dbz = z; e.lat = lt;
    return e;
  endfunction

  // Reference results from native wide arithmetic, independent of the iteration.
  function automatic exp_t modelOp(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    longint      p, q, r;
    logic [63:0] pu;
    exp_t        e;
    e = mkExp("random", mHi, mLo, 1'b0, 33);
    case (o)
      OP_MULT:  begin p = longint'($signed(x)) * longint'($signed(y)); e.hi = p[63:32]; e.lo = p[31:0]; end
      OP_MULTU: begin pu = {32'h0, x} * {32'h0, y}; e.hi = pu[63:32]; e.lo = pu[31:0]; end
      OP_DIV:   begin
        q = longint'($signed(x)) / longint'($signed(y));
        r = longint'($signed(x)) % longint'($signed(y));
        e.hi = r[31:0]; e.lo = q[31:0];
      end
      default:  begin e.hi = x % y; e.lo = x / y; end
    endcase
    return e;
  endfunction

  task automatic issue(input logic [3:0] cOp, input logic [31:0] cA, input logic [31:0] cB, input exp_t e);
    @(negedge clk);
    start = 1'b1; op = cOp; a = cA; b = cB;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0; op = 4'hF; a = $urandom; b = $urandom;
  endtask

  task automatic waitDone(output int lat, output bit timedOut);
    lat = 0;
    while (done !== 1'b1 && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    timedOut = (done !== 1'b1);
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; op = 4'hF; a = '0; b = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    mHi = '0; mLo = '0;
    nCompared++; if (hi !== 32'h0) begin nMismatched++; $display("[TB] FAIL reset_hi: got %h want 0", hi); end
    nCompared++; if (lo !== 32'h0) begin nMismatched++; $display("[TB] FAIL reset_lo: got %h want 0", lo); end
    nCompared++; if (busy !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    nCompared++; if (done !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_done: got %b want 0", done); end
    nCompared++; if (dbz !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_dbz: got %b want 0", dbz); end
  endtask

  task automatic test_mthi_mtlo;
    exp_t e; int lat; bit to;
    exp_t tE[2]; logic [3:0] tOp[2]; logic [31:0] tA[2];
    tOp[0] = OP_MTHI; tA[0] = 32'hDEADBEEF; tE[0] = mkExp("mthi", 32'hDEADBEEF, 32'h0, 1'b0, 0);
    tOp[1] = OP_MTLO; tA[1] = 32'hCAFEF00D; tE[1] = mkExp("mtlo", 32'hDEADBEEF, 32'hCAFEF00D, 1'b0, 0);
    for (int i = 0; i < 2; i++) begin
      issue(tOp[i], tA[i], 32'h0, tE[i]);
      nCompared++; if (busy !== 1'b0) begin nMismatched++; $display("[TB] FAIL %s busy: got %b want 0", tE[i].name, busy); end
      waitDone(lat, to);
      e = sb.pop_front();
      nCompared++; if (to || lat != e.lat) begin nMismatched++; $display("[TB] FAIL %s latency: got %0d want %0d", e.name, lat, e.lat); end
      nCompared++; if (hi !== e.hi) begin nMismatched++; $display("[TB] FAIL %s hi: got %h want %h", e.name, hi, e.hi); end
      nCompared++; if (lo !== e.lo) begin nMismatched++; $display("[TB] FAIL %s lo: got %h want %h", e.name, lo, e.lo); end
      @(negedge clk);
      nCompared++; if (done !== 1'b0) begin nMismatched++; $display("[TB] FAIL %s done_pulse: got %b want 0", e.name, done); end
      mHi = e.hi; mLo = e.lo;
    end
  endtask

  task automatic test_mul;
    exp_t e; int lat; bit to;
    exp_t tE[3]; logic [3:0] tOp[3]; logic [31:0] tA[3], tB[3];
    tOp[0] = OP_MULT;  tA[0] = 32'hFFFFFFFE; tB[0] = 32'd3; tE[0] = mkExp("mult_m2x3", 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0, 33);
    tOp[1] = OP_MULTU; tA[1] = 32'hFFFFFFFE; tB[1] = 32'd3; tE[1] = mkExp("multu_fffe_x3", 32'h2, 32'hFFFFFFFA, 1'b0, 33);
    tOp[2] = OP_MULT;  tA[2] = 32'h80000000; tB[2] = 32'h80000000; tE[2] = mkExp("mult_min_sq", 32'h40000000, 32'h0, 1'b0, 33);
    for (int i = 0; i < 3; i++) begin
      issue(tOp[i], tA[i], tB[i], tE[i]);
      nCompared++; if (busy !== 1'b1) begin nMismatched++; $display("[TB] FAIL %s busy: got %b want 1", tE[i].name, busy); end
      waitDone(lat, to);
      e = sb.pop_front();
      nCompared++; if (to || lat != e.lat) begin nMismatched++; $display("[TB] FAIL %s latency: got %0d want %0d", e.name, lat, e.lat); end
      nCompared++; if (hi !== e.hi) begin nMismatched++; $display("[TB] FAIL %s hi: got %h want %h", e.name, hi, e.hi); end
      nCompared++; if (lo !== e.lo) begin nMismatched++; $display("[TB] FAIL %s lo: got %h want %h", e.name, lo, e.lo); end
      nCompared++; if (dbz !== e.dbz || busy !== 1'b0) begin nMismatched++; $display("[TB] FAIL %s dbz_busy: got %b%b want %b0", e.name, dbz, busy, e.dbz); end
      @(negedge clk);
      nCompared++; if (done !== 1'b0) begin nMismatched++; $display("[TB] FAIL %s done_pulse: got %b want 0", e.name, done); end
      mHi = e.hi; mLo = e.lo;
    end
  endtask

  task automatic test_div;
    exp_t e; int lat; bit to;
    exp_t tE[4]; logic [3:0] tOp[4]; logic [31:0] tA[4], tB[4];
    tOp[0] = OP_DIV;  tA[0] = 32'hFFFFFFF9; tB[0] = 32'd2; tE[0] = mkExp("div_m7_2", 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33);
    tOp[1] = OP_DIVU; tA[1] = 32'd7; tB[1] = 32'd2; tE[1] = mkExp("divu_7_2", 32'd1, 32'd3, 1'b0, 33);
    tOp[2] = OP_DIV;  tA[2] = 32'h80000000; tB[2] = 32'hFFFFFFFF; tE[2] = mkExp("div_min_m1", 32'h0, 32'h80000000, 1'b0, 33);
    tOp[3] = OP_DIV;  tA[3] = 32'd7; tB[3] = 32'hFFFFFFFE; tE[3] = mkExp("div_7_m2", 32'd1, 32'hFFFFFFFD, 1'b0, 33);
    for (int i = 0; i < 4; i++) begin
      issue(tOp[i], tA[i], tB[i], tE[i]);
      waitDone(lat, to);
      e = sb.pop_front();
      nCompared++; if (to || lat != e.lat) begin nMismatched++; $display("[TB] FAIL %s latency: got %0d want %0d", e.name, lat, e.lat); end
      nCompared++; if (hi !== e.hi) begin nMismatched++; $display("[TB] FAIL %s hi: got %h want %h", e.name, hi, e.hi); end
      nCompared++; if (lo !== e.lo) begin nMismatched++; $display("[TB] FAIL %s lo: got %h want %h", e.name, lo, e.lo); end
      nCompared++; if (dbz !== e.dbz) begin nMismatched++; $display("[TB] FAIL %s dbz: got %b want %b", e.name, dbz, e.dbz); end
      mHi = e.hi; mLo = e.lo;
    end
  endtask

  task automatic test_divzero;
    exp_t e; int lat; bit to;
    exp_t tE[4]; logic [3:0] tOp[4]; logic [31:0] tA[4], tB[4];
    tOp[0] = OP_MTHI; tA[0] = 32'd5;   tB[0] = 32'h0; tE[0] = mkExp("dz_mthi", 32'd5, mLo, 1'b0, 0);
    tOp[1] = OP_MTLO; tA[1] = 32'd9;   tB[1] = 32'h0; tE[1] = mkExp("dz_mtlo", 32'd5, 32'd9, 1'b0, 0);
    tOp[2] = OP_DIVU; tA[2] = 32'd123; tB[2] = 32'h0; tE[2] = mkExp("divu_by0", 32'd5, 32'd9, 1'b1, 0);
    tOp[3] = OP_DIV;  tA[3] = 32'hFFFFFFF0; tB[3] = 32'h0; tE[3] = mkExp("div_by0", 32'd5, 32'd9, 1'b1, 0);
    for (int i = 0; i < 4; i++) begin
      issue(tOp[i], tA[i], tB[i], tE[i]);
      nCompared++; if (busy !== 1'b0) begin nMismatched++; $display("[TB] FAIL %s busy: got %b want 0", tE[i].name, busy); end
      waitDone(lat, to);
      e = sb.pop_front();
      nCompared++; if (to || lat != e.lat) begin nMismatched++; $display("[TB] FAIL %s latency: got %0d want %0d", e.name, lat, e.lat); end
      nCompared++; if (hi !== e.hi) begin nMismatched++; $display("[TB] FAIL %s hi: got %h want %h", e.name, hi, e.hi); end
      nCompared++; if (lo !== e.lo) begin nMismatched++; $display("[TB] FAIL %s lo: got %h want %h", e.name, lo, e.lo); end
      nCompared++; if (dbz !== e.dbz) begin nMismatched++; $display("[TB] FAIL %s dbz: got %b want %b", e.name, dbz, e.dbz); end
      @(negedge clk);
      nCompared++; if (done !== 1'b0 || dbz !== 1'b0) begin nMismatched++; $display("[TB] FAIL %s flag_pulse: got %b%b want 00", e.name, done, dbz); end
      mHi = e.hi; mLo = e.lo;
    end
  endtask

  task automatic test_ignore_busy;
    exp_t e; int lat; bit to; bit sawDone;
    issue(OP_MULT, 32'd3, 32'd4, mkExp("mult_3x4_ignore", 32'h0, 32'd12, 1'b0, 33));
    repeat (10) @(negedge clk);
    nCompared++; if (busy !== 1'b1) begin nMismatched++; $display("[TB] FAIL ignore_busy_mid: got %b want 1", busy); end
    start = 1'b1; op = OP_MTLO; a = 32'h1234;
    @(negedge clk);
    start = 1'b0; op = 4'hF;
    waitDone(lat, to);
    lat = lat + 11;
    e = sb.pop_front();
    nCompared++; if (to || lat != e.lat) begin nMismatched++; $display("[TB] FAIL %s latency: got %0d want %0d", e.name, lat, e.lat); end
    nCompared++; if (hi !== e.hi) begin nMismatched++; $display("[TB] FAIL %s hi: got %h want %h", e.name, hi, e.hi); end
    nCompared++; if (lo !== e.lo) begin nMismatched++; $display("[TB] FAIL %s lo: got %h want %h", e.name, lo, e.lo); end
    sawDone = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (done === 1'b1) sawDone = 1'b1;
    end
    nCompared++; if (sawDone !== 1'b0 || lo !== 32'd12) begin nMismatched++; $display("[TB] FAIL ignore_not_queued: done %b lo %h want done 0 lo 0000000c", sawDone, lo); end
    mHi = e.hi; mLo = e.lo;
  endtask

  task automatic test_reset_mid;
    bit sawDone, sawBusy;
    @(negedge clk);
    start = 1'b1; op = OP_MULT; a = 32'h1234; b = 32'h5678;
    @(negedge clk);
    start = 1'b0; op = 4'hF;
    repeat (19) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    nCompared++; if (busy !== 1'b0) begin nMismatched++; $display("[TB] FAIL resetmid_busy: got %b want 0", busy); end
    nCompared++; if (hi !== 32'h0 || lo !== 32'h0) begin nMismatched++; $display("[TB] FAIL resetmid_hilo: got %h_%h want 0_0", hi, lo); end
    sawDone = 1'b0; sawBusy = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) sawDone = 1'b1;
      if (busy === 1'b1) sawBusy = 1'b1;
    end
    nCompared++; if (sawDone !== 1'b0 || sawBusy !== 1'b0) begin nMismatched++; $display("[TB] FAIL resetmid_quiet: done %b busy %b want 0 0", sawDone, sawBusy); end
    mHi = '0; mLo = '0;
  endtask

  task automatic test_back_to_back;
    exp_t e; int lat; bit to;
    @(negedge clk);
    start = 1'b1; op = OP_MTHI; a = 32'h11;
    @(negedge clk);
    nCompared++; if (done !== 1'b1 || hi !== 32'h11) begin nMismatched++; $display("[TB] FAIL b2b_mthi: done %b hi %h want 1 00000011", done, hi); end
    op = OP_MTLO; a = 32'h22;
    @(negedge clk);
    nCompared++; if (done !== 1'b1 || lo !== 32'h22 || dbz !== 1'b0) begin nMismatched++; $display("[TB] FAIL b2b_mtlo: done %b lo %h dbz %b want 1 00000022 0", done, lo, dbz); end
    op = OP_DIVU; a = 32'd1; b = 32'd0;
    @(negedge clk);
    start = 1'b0; op = 4'hF;
    nCompared++; if (done !== 1'b1 || dbz !== 1'b1 || busy !== 1'b0) begin nMismatched++; $display("[TB] FAIL b2b_divzero: done %b dbz %b busy %b want 1 1 0", done, dbz, busy); end
    nCompared++; if (hi !== 32'h11 || lo !== 32'h22) begin nMismatched++; $display("[TB] FAIL b2b_hilo: got %h_%h want 00000011_00000022", hi, lo); end
    issue(OP_MULTU, 32'd5, 32'd6, mkExp("b2b_multu_5x6", 32'h0, 32'd30, 1'b0, 33));
    waitDone(lat, to);
    e = sb.pop_front();
    nCompared++; if (to || lat != e.lat) begin nMismatched++; $display("[TB] FAIL %s latency: got %0d want %0d", e.name, lat, e.lat); end
    nCompared++; if (hi !== e.hi || lo !== e.lo) begin nMismatched++; $display("[TB] FAIL %s hilo: got %h_%h want %h_%h", e.name, hi, lo, e.hi, e.lo); end
    start = 1'b1; op = OP_MTLO; a = 32'h77;
    @(negedge clk);
    start = 1'b0; op = 4'hF;
    nCompared++; if (done !== 1'b1 || lo !== 32'h77 || hi !== 32'h0) begin nMismatched++; $display("[TB] FAIL b2b_accept_in_done: done %b hi %h lo %h want 1 0 77", done, hi, lo); end
    mHi = 32'h0; mLo = 32'h77;
  endtask

  task automatic test_madd;
    exp_t e; int lat; bit to; bit sawDone, sawBusy;
    logic [3:0] probe[$];
`ifdef HILO_MADD_EN
    exp_t tE[8]; logic [3:0] tOp[8]; logic [31:0] tA[8], tB[8];
    tOp[0] = OP_MTLO;  tA[0] = 32'hFFFFFFFF; tB[0] = '0; tE[0] = mkExp("ma_mtlo", mHi, 32'hFFFFFFFF, 1'b0, 0);
    tOp[1] = OP_MTHI;  tA[1] = 32'h0; tB[1] = '0; tE[1] = mkExp("ma_mthi", 32'h0, 32'hFFFFFFFF, 1'b0, 0);
    tOp[2] = OP_MADDU; tA[2] = 32'd1; tB[2] = 32'd1; tE[2] = mkExp("maddu_1x1", 32'h1, 32'h0, 1'b0, 33);
    tOp[3] = OP_MTHI;  tA[3] = 32'h0; tB[3] = '0; tE[3] = mkExp("ma_mthi0", 32'h0, 32'h0, 1'b0, 0);
    tOp[4] = OP_MSUB;  tA[4] = 32'd1; tB[4] = 32'd1; tE[4] = mkExp("msub_1x1", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 33);
    tOp[5] = OP_MTHI;  tA[5] = 32'h0; tB[5] = '0; tE[5] = mkExp("ma_mthi1", 32'h0, 32'hFFFFFFFF, 1'b0, 0);
    tOp[6] = OP_MTLO;  tA[6] = 32'd10; tB[6] = '0; tE[6] = mkExp("ma_mtlo10", 32'h0, 32'd10, 1'b0, 0);
    tOp[7] = OP_MADD;  tA[7] = 32'hFFFFFFFE; tB[7] = 32'd3; tE[7] = mkExp("madd_m2x3", 32'h0, 32'd4, 1'b0, 33);
    probe = '{4'hA, 4'hF};
    for (int i = 0; i < 8; i++) begin
`else
    exp_t tE[2]; logic [3:0] tOp[2]; logic [31:0] tA[2], tB[2];
    tOp[0] = OP_MTHI; tA[0] = 32'h55; tB[0] = '0; tE[0] = mkExp("nm_mthi", 32'h55, mLo, 1'b0, 0);
    tOp[1] = OP_MTLO; tA[1] = 32'h66; tB[1] = '0; tE[1] = mkExp("nm_mtlo", 32'h55, 32'h66, 1'b0, 0);
    probe = '{OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU, 4'hA, 4'hF};
    for (int i = 0; i < 2; i++) begin
`endif
      issue(tOp[i], tA[i], tB[i], tE[i]);
      waitDone(lat, to);
      e = sb.pop_front();
      nCompared++; if (to || lat != e.lat) begin nMismatched++; $display("[TB] FAIL %s latency: got %0d want %0d", e.name, lat, e.lat); end
      nCompared++; if (hi !== e.hi || lo !== e.lo) begin nMismatched++; $display("[TB] FAIL %s hilo: got %h_%h want %h_%h", e.name, hi, lo, e.hi, e.lo); end
      mHi = e.hi; mLo = e.lo;
    end
    foreach (probe[k]) begin
      @(negedge clk);
      start = 1'b1; op = probe[k]; a = 32'd7; b = 32'd9;
      @(negedge clk);
      start = 1'b0; op = 4'hF;
      sawDone = (done === 1'b1); sawBusy = (busy === 1'b1);
      repeat (40) begin
        @(negedge clk);
        if (done === 1'b1) sawDone = 1'b1;
        if (busy === 1'b1) sawBusy = 1'b1;
      end
      nCompared++; if (sawDone || sawBusy || hi !== mHi || lo !== mLo) begin nMismatched++; $display("[TB] FAIL noop_%h: done %b busy %b hilo %h_%h want 0 0 %h_%h", probe[k], sawDone, sawBusy, hi, lo, mHi, mLo); end
    end
  endtask

  task automatic test_random;
    exp_t e; int lat; bit to;
    logic [3:0] rOp; logic [31:0] rA, rB;
    for (int i = 0; i < 10; i++) begin
      rOp = 4'($urandom_range(0, 3));
      rA = $urandom;
      rB = (i % 3 == 0) ? 32'($urandom_range(1, 20)) : $urandom;
      if (rB == 32'h0) rB = 32'h1;
      e = modelOp(rOp, rA, rB);
      issue(rOp, rA, rB, e);
      waitDone(lat, to);
      e = sb.pop_front();
      nCompared++; if (to || lat != e.lat) begin nMismatched++; $display("[TB] FAIL rnd%0d latency: got %0d want %0d", i, lat, e.lat); end
      nCompared++; if (hi !== e.hi || lo !== e.lo) begin nMismatched++; $display("[TB] FAIL rnd%0d op%0d %h,%h hilo: got %h_%h want %h_%h", i, rOp, rA, rB, hi, lo, e.hi, e.lo); end
      mHi = e.hi; mLo = e.lo;
    end
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_mthi_mtlo();
    test_mul();
    test_div();
    test_divzero();
    test_ignore_busy();
    test_reset_mid();
    test_back_to_back();
    test_madd();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
